stuff_data_mapper: RTL
======================

Name: stuff_data_mapper

Overview:
- Downstream of the stuff-or-data decision stage; consumes its per-slot sof/valid/ds stream.
- Buffers client payload bytes in an internal FIFO.
- Emits one output byte per slot: a FIFO byte when ds=1, or STUFF_BYTE when ds=0.
- Frame start is marked on the first emitted slot of each frame; FIFO underflow is flagged.

Parameters:
DATA_W, 8, payload byte width
MPT_W, 8, width of the per-frame data counter; matches the upstream pm/cm width
FIFO_DEPTH, 16, payload FIFO entries; power of 2, >= 2
STUFF_BYTE, 8'h00, value emitted on stuff slots and on underflow slots

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
s_data  in  DATA_W  client payload byte
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept a byte
slot_sof  in  1  frame-start pulse from upstream sof_out
slot_valid  in  1  slot strobe from upstream valid_out
slot_ds  in  1  1=data slot, 0=stuff slot; qualified by slot_valid
err_clr  in  1  clears underflow
m_data  out  DATA_W  mapped slot byte
m_valid  out  1  m_data valid
m_sof  out  1  first slot of frame; qualified by m_valid
m_is_stuff  out  1  m_data is stuff or underflow filler
underflow  out  1  sticky: a data slot found the FIFO empty
data_cnt  out  MPT_W  real data bytes emitted in current frame
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: m_valid, m_sof, m_is_stuff, m_data, underflow, data_cnt, fifo_level all 0; s_ready 0.
  - FIFO flushed; state IDLE.
  - Reset mid-frame discards buffered bytes; a new slot_sof is required before any output.
- FIFO:
  - Write on s_valid & s_ready.
  - s_ready = rst_n & (fifo_level < FIFO_DEPTH), combinational.
  - No write bypass when full, even if a read occurs in the same cycle.
  - Read on slot_valid & slot_ds & (fifo_level != 0) in a state that emits.
  - Empty check uses occupancy before this cycle's write; a byte written in the same cycle is not readable.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is +1 on write only, -1 on read only, unchanged on both.
- States:
  - IDLE: slot_valid ignored, m_valid=0. slot_sof -> ARMED.
  - ARMED: next emitted slot carries m_sof=1 -> RUN.
  - RUN: every slot_valid emits. slot_sof -> ARMED.
  - slot_sof and slot_valid in the same cycle (any state): the slot is the first of the new frame (m_sof=1), next state RUN.
- slot_sof effects: clears data_cnt to 0 in the same edge; a data byte counted in that cycle makes data_cnt=1.
- Output timing (registered, latency 1): when a slot is accepted in cycle N, outputs are valid in cycle N+1.
  - m_valid=1.
  - ds=0: m_data=STUFF_BYTE, m_is_stuff=1, no FIFO read.
  - ds=1, FIFO non-empty: m_data=FIFO head, m_is_stuff=0; FIFO popped; data_cnt+1, saturating at all-ones.
  - ds=1, FIFO empty: m_data=STUFF_BYTE, m_is_stuff=1; underflow set; data_cnt unchanged.
  - No slot accepted: m_valid=0, m_sof=0; m_data and m_is_stuff hold.
- underflow:
  - Cleared by err_clr.
  - If a set event and err_clr occur in the same cycle, set wins.
- slot_ds is ignored when slot_valid=0. Slots may arrive back-to-back, one per cycle, with no back-pressure toward upstream.

Test Plan:
- Reset, then push bytes 0x11..0x15; slot_sof; ds = 1,0,1,1,0,1,0,1 on consecutive cycles.
  -> m_data = 11,00,12,13,00,14,00,15.
  -> m_sof only on first; m_is_stuff = 0,1,0,0,1,0,1,0.
  -> data_cnt=5; fifo_level=0; underflow=0.
- FIFO holds 0xA0 only; slot_sof; ds = 1,1,0.
  -> m_data = A0,00,00; m_is_stuff = 0,1,1.
  -> underflow=1 from the second output cycle; stays set until err_clr pulse, then 0.
- Fill 16 bytes.
  -> s_ready=0 at fifo_level=16.
  -> One ds=1 slot with s_valid held: no write that cycle; s_ready=1 the cycle after; level 15 -> 16.
- Slots with slot_valid=1 before any slot_sof -> m_valid stays 0; FIFO untouched.
- Mid-frame: slot_sof coincident with a ds=1 slot, FIFO holds 0x33 -> m_data=33, m_sof=1, data_cnt=1.
- Assert rst_n=0 asynchronously mid-frame with fifo_level=4.
  -> All outputs 0 immediately; after release, level=0 and ds slots ignored until slot_sof.

Source files
------------

// File: rtl/stuff_data_mapper.sv
// Slot mapper: fills each upstream slot with a buffered payload byte
// or a stuff byte, marks frame start and flags payload underflow.
module stuff_data_mapper #(
  parameter int DATA_W = 8,
  parameter int MPT_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] STUFF_BYTE = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic s_valid,
  output logic s_ready,
  input  logic slot_sof,
  input  logic slot_valid,
  input  logic slot_ds,
  input  logic err_clr,
  output logic [DATA_W-1:0] m_data,
  output logic m_valid,
  output logic m_sof,
  output logic m_is_stuff,
  output logic underflow,
  output logic [MPT_W-1:0] data_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic accept, first, wr, rd, empty_hit;
  logic sof_emit, sof_only, run_emit;

  assign fifo_level = level;
  assign s_ready = rst_n & (level < FULL);
  assign wr = s_valid & s_ready;

  // Slot acceptance, frame-start marking and next state
  always_comb begin
    accept = slot_valid & (slot_sof | (state_q != IDLE));
    first = accept & (slot_sof | (state_q == ARMED));
    rd = accept & slot_ds & (level != '0);
    empty_hit = accept & slot_ds & (level == '0);
    sof_emit = slot_sof & accept;
    sof_only = slot_sof & ~accept;
    run_emit = ~slot_sof & accept;
    state_d = state_q;
    unique case (1'b1)
      sof_emit: state_d = RUN;
      sof_only: state_d = ARMED;
      run_emit: state_d = RUN;
      default: ;
    endcase
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Payload storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10: level <= level + LW'(1);
        2'b01: level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // Registered slot output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sof <= 1'b0;
      m_data <= '0;
      m_is_stuff <= 1'b0;
    end else begin
      m_valid <= accept;
      m_sof <= first;
      if (accept) begin
        m_data <= rd ? mem[rd_ptr] : STUFF_BYTE;
        m_is_stuff <= ~rd;
      end
    end
  end

  // Per-frame real data byte counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_cnt <= '0;
    else if (slot_sof) data_cnt <= MPT_W'(rd);
    else if (rd && !(&data_cnt)) data_cnt <= data_cnt + MPT_W'(1);
  end

  // Sticky underflow flag; a new event beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underflow <= 1'b0;
    else if (empty_hit) underflow <= 1'b1;
    else if (err_clr) underflow <= 1'b0;
  end

endmodule
